slice_merge_reg: RTL

Parametrised partial-write assembly register: accumulates bit-masked slice writes from several lanes into one WIDTH-bit word, tracks per-bit coverage, and presents the completed word on a valid/ready output. It is the clocked counterpart of piecewise net assignment (field, element and bit-range writes to one packed net), and sits between slice producers and any consumer that needs whole words. Multi-driver conflicts and overwrites of already-covered bits are detected and flagged.

---
 rtl/slice_merge_reg.sv | 130 +++++++++++++
 1 files changed

// File: rtl/slice_merge_reg.sv
// ============================================================================
// slice_merge_reg : assembles bit-masked lane writes into one valid/ready word
// Optional multi-driver / overwrite detection: SLICE_MERGE_OVERLAP_CHECK_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

module slice_merge_reg #(
  parameter int WIDTH = 8,
  parameter int LANES = 2,
  localparam int CW   = $clog2(WIDTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LANES-1:0]       wr_valid,
  input  logic [LANES*WIDTH-1:0] wr_data,
  input  logic [LANES*WIDTH-1:0] wr_mask,
  output logic                   wr_ready,
  input  logic                   flush,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  input  logic                   out_ready,
  output logic [CW-1:0]          cov_count,
  output logic                   conflict_err,
  input  logic                   err_clear
);

  typedef enum logic [0:0] {
    S_FILL = 1'b0,
    S_FULL = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [WIDTH-1:0] cov_q, cov_d;

  logic             emit;
  logic [WIDTH-1:0] lane_mask;
  logic [WIDTH-1:0] wr_bits;
  logic [WIDTH-1:0] wr_vals;
  logic [WIDTH-1:0] multi_hit;
  logic [WIDTH-1:0] overwrite_hit;
  logic [WIDTH-1:0] base_word;
  logic [WIDTH-1:0] base_cov;
  logic [CW-1:0]    pop;

  always_comb begin
    wr_ready  = !flush && ((state_q == S_FILL) || out_ready);
    emit      = (state_q == S_FULL) && out_ready && !flush;
    lane_mask = '0;
    wr_bits   = '0;
    wr_vals   = '0;
    multi_hit = '0;
    // Ascending lane order lets the highest-indexed lane win each bit.
    for (int i = 0; i < LANES; i++) begin
      if (wr_ready && wr_valid[i]) begin
        lane_mask = wr_mask[i*WIDTH +: WIDTH];
        multi_hit = multi_hit | (wr_bits & lane_mask);
        wr_vals   = (wr_vals & ~lane_mask) | (wr_data[i*WIDTH +: WIDTH] & lane_mask);
        wr_bits   = wr_bits | lane_mask;
      end
    end

    // A handshaking word is retired before this cycle's writes land.
    base_word     = emit ? '0 : word_q;
    base_cov      = emit ? '0 : cov_q;
    overwrite_hit = wr_bits & base_cov;

    state_d = state_q;
    word_d  = word_q;
    cov_d   = cov_q;
    if (flush) begin
      state_d = S_FILL;
      word_d  = '0;
      cov_d   = '0;
    end else if ((state_q == S_FILL) || out_ready) begin
      word_d  = (base_word & ~wr_bits) | (wr_vals & wr_bits);
      cov_d   = base_cov | wr_bits;
      state_d = (&cov_d) ? S_FULL : S_FILL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FILL;
      word_q  <= '0;
      cov_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      cov_q   <= cov_d;
    end
  end

  always_comb begin
    pop = '0;
    for (int b = 0; b < WIDTH; b++) begin
      pop = pop + CW'(cov_q[b]);
    end
  end

  assign out_valid = (state_q == S_FULL);
  assign out_data  = word_q;
  assign cov_count = pop;

`ifdef SLICE_MERGE_OVERLAP_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (err_clear) err_d = 1'b0;
    // A fresh conflict outranks a same-cycle clear.
    if ((|multi_hit) || (|overwrite_hit)) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign conflict_err = err_q;
`else
  logic unused_detect;
  assign unused_detect = err_clear ^ (|multi_hit) ^ (|overwrite_hit);
  assign conflict_err  = 1'b0;
`endif

endmodule

`default_nettype wire
